// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round counts, controller FSM encoding,
// GF(2^8) arithmetic helpers and the inverse S-box.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;
  localparam int NR_AES192   = 12;
  localparam int NR_AES256   = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant operand it folds to a few XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey,
// followed by InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] rk,
  input  logic                   last,
  output logic [AES_BLOCK_W-1:0] state_out
);

  // Byte i of the block lives in element [15-i]; byte i is row i%4, column i/4.
  logic [15:0][7:0] st_b;
  logic [15:0][7:0] sub_b;
  logic [15:0][7:0] ark_b;
  logic [15:0][7:0] mix_b;

  assign st_b = state_in;

  // Row r rotates right by r columns, so output column c reads input column c-r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub_b[15-(4*c+r)] = inv_sbox(st_b[15-(4*((c-r+4)%4)+r)]);
    end
  end

  assign ark_b = sub_b ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_b[15-(4*c+0)];
    assign a1 = ark_b[15-(4*c+1)];
    assign a2 = ark_b[15-(4*c+2)];
    assign a3 = ark_b[15-(4*c+3)];
    assign mix_b[15-(4*c+0)] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mix_b[15-(4*c+1)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mix_b[15-(4*c+2)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mix_b[15-(4*c+3)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign state_out = last ? ark_b : mix_b;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one inverse round per clock over a
// 128-bit state register, round keys fetched by index from an external store.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_AES256,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic [IDX_W-1:0]       rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] NR_IDX    = IDX_W'(NR);
  localparam logic [IDX_W-1:0] NR_M1_IDX = IDX_W'(NR - 1);

  fsm_t                   fsm_q, fsm_d;
  logic [IDX_W-1:0]       rnd_q;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [AES_BLOCK_W-1:0] round_out;

  aes_inv_round u_round (
    .state_in  (state_q),
    .rk        (rk),
    .last      (fsm_q == ST_FINAL),
    .state_out (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next state and handshake/key-index outputs.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = NR_IDX;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = NR_IDX;
        if (in_valid) fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        rk_idx = rnd_q;
        if (rnd_q == IDX_W'(1)) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        rk_idx = '0;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        rk_idx    = '0;
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        rk_idx = NR_IDX;
        fsm_d  = ST_IDLE;
      end
    endcase
  end

  // Datapath: initial key add on accept, one round per cycle, round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rnd_q   <= NR_IDX;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= in_block ^ rk;
            rnd_q   <= NR_M1_IDX;
          end
        end
        ST_ROUND: begin
          state_q <= round_out;
          // Counter saturates at zero so it can never wrap past round 0.
          if (rnd_q >= IDX_W'(2)) rnd_q <= rnd_q - IDX_W'(1);
          else                    rnd_q <= '0;
        end
        ST_FINAL: state_q <= round_out;
        ST_DONE:  if (out_ready) rnd_q <= NR_IDX;
        default:  rnd_q <= NR_IDX;
      endcase
    end
  end

  assign out_block = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: AES-256 key schedule and a forward-cipher
// reference built from GF(2^8) arithmetic, table of decrypt vectors, plus
// back-pressure, back-to-back, spurious-input and mid-operation reset sequences.
module tb_aes_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  logic [127:0] rkeys [0:15];
  logic [7:0]   sbox  [0:255];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [0:4];

  aes_inv_cipher_ctrl #(.NR(14), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign rk = rkeys[rk_idx];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Forward S-box from the field inverse and the affine map.
  task automatic build_sbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rkeys[15] = '0;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st;
    st = pt ^ rkeys[0];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 14) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ rkeys[r];
    end
    return st;
  endfunction

  // One transaction with exact latency and rk_idx trace checks.
  // hold: cycles of out_ready=0 in DONE; spur: toggle inputs while busy.
  task automatic run_tx(input logic [127:0] ct, input logic [127:0] pt,
                        input string nm, input int hold, input bit spur);
    int n;
    bit trace_ok, early;
    logic [127:0] held;
    n = 0;
    while (!in_ready && n < 50) begin step; n++; end
    chk({nm, ".idle_ready"}, 128'(in_ready), 128'd1);
    chk({nm, ".idle_rkidx"}, 128'(rk_idx), 128'd14);
    in_valid = 1'b1; in_block = ct; out_ready = 1'b0;
    step;
    in_valid = 1'b0; in_block = {4{$urandom}};
    trace_ok = 1'b1; early = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (rk_idx !== 4'(14 - c)) trace_ok = 1'b0;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
      if (spur) begin
        in_valid = 1'($urandom_range(0, 1));
        in_block = {4{$urandom}};
      end
      step;
    end
    in_valid = 1'b0;
    chk({nm, ".rk_trace"}, 128'(trace_ok), 128'd1);
    chk({nm, ".no_early_valid"}, 128'(early), 128'd0);
    chk({nm, ".out_valid"}, 128'(out_valid), 128'd1);
    chk({nm, ".out_block"}, out_block, pt);
    chk({nm, ".done_rkidx"}, 128'(rk_idx), 128'd0);
    held = out_block;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_block = {4{$urandom}};
      step;
      chk({nm, ".bp_valid"}, 128'(out_valid), 128'd1);
      chk({nm, ".bp_block"}, out_block, held);
      chk({nm, ".bp_in_ready"}, 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({nm, ".hs_in_ready"}, 128'(in_ready), 128'd0);
    step;
    out_ready = 1'b0;
    chk({nm, ".post_ready"}, 128'(in_ready), 128'd1);
    chk({nm, ".post_valid"}, 128'(out_valid), 128'd0);
    chk({nm, ".post_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int acc_t [0:1];
    int acc_cnt, got;
    logic [127:0] res [0:1];
    bit acc, pulse;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    build_sbox;
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    vecs[0] = '{ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1].pt = 128'h0;
    vecs[2].pt = {128{1'b1}};
    vecs[3].pt = 128'h0123456789abcdeffedcba9876543210;
    vecs[4].pt = 128'h80000000000000000000000000000001;
    for (int i = 1; i < 5; i++) vecs[i].ct = enc(vecs[i].pt);
    chk("model_kat", enc(vecs[0].pt), vecs[0].ct);

    // Reset state.
    step; step;
    chk("rst.in_ready", 128'(in_ready), 128'd1);
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.out_valid", 128'(out_valid), 128'd0);
    chk("rst.rk_idx", 128'(rk_idx), 128'd14);
    rst = 1'b0;

    // Table of decrypt vectors.
    for (int i = 0; i < 5; i++)
      run_tx(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i), 0, 1'b0);

    // Back-pressure in DONE.
    run_tx(vecs[0].ct, vecs[0].pt, "backpressure", 5, 1'b0);

    // Spurious input while busy.
    run_tx(vecs[3].ct, vecs[3].pt, "spurious", 0, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    in_block = vecs[0].ct; in_valid = 1'b1; out_ready = 1'b1;
    acc_cnt = 0; got = 0;
    for (int c = 0; c < 60 && got < 2; c++) begin
      acc = in_valid && in_ready;
      if (acc && acc_cnt < 2) begin acc_t[acc_cnt] = c; acc_cnt++; end
      if (out_valid && got < 2) begin res[got] = out_block; got++; end
      step;
      if (acc && acc_cnt == 1) in_block = vecs[1].ct;
      else if (acc && acc_cnt == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b.accepts", 128'(acc_cnt), 128'd2);
    chk("b2b.gap", 128'(acc_t[1] - acc_t[0]), 128'd16);
    chk("b2b.results", 128'(got), 128'd2);
    chk("b2b.res0", res[0], vecs[0].pt);
    chk("b2b.res1", res[1], vecs[1].pt);
    step; step;

    // Reset mid-operation discards the block.
    in_valid = 1'b1; in_block = vecs[0].ct;
    step;
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) step;
    chk("midrst.busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst.in_ready", 128'(in_ready), 128'd1);
    chk("midrst.busy", 128'(busy), 128'd0);
    chk("midrst.out_valid", 128'(out_valid), 128'd0);
    chk("midrst.rk_idx", 128'(rk_idx), 128'd14);
    pulse = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) pulse = 1'b1;
      step;
    end
    chk("midrst.no_pulse", 128'(pulse), 128'd0);
    run_tx(vecs[0].ct, vecs[0].pt, "after_rst", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
